// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file and its busy tracker.
// Holds the default geometry and the register-count helper.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Number of architectural registers addressed by an addr_w-bit index.
  function automatic int nregs(input int addr_w);
    return 32'sd1 <<< addr_w;
  endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register pending-writeback scoreboard with a registered busy population count.
// Issue sets a bit, any enabled writeback clears it, and issue wins when both hit one register.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_reg,
  input  logic                     wr_en_a,
  input  logic [ADDR_W-1:0]        wr_reg_a,
  input  logic                     wr_en_b,
  input  logic [ADDR_W-1:0]        wr_reg_b,
  output logic [nregs(ADDR_W)-1:0] busy_vec,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int NREGS = nregs(ADDR_W);
  localparam bit ZR    = (ZERO_REG != 0);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [ADDR_W:0]  cnt_r;
  logic [ADDR_W:0]  cnt_nxt_s;
  logic             set_s;
  logic             clr_s;

  // Next busy vector and its population count.
  always_comb begin
    busy_nxt_s = busy_r;
    cnt_nxt_s  = {(ADDR_W+1){1'b0}};
    set_s      = 1'b0;
    clr_s      = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      set_s = issue_en && (issue_reg == ADDR_W'(r));
      clr_s = (wr_en_a && (wr_reg_a == ADDR_W'(r))) ||
              (wr_en_b && (wr_reg_b == ADDR_W'(r)));
      if (ZR && (r == 0)) begin
        busy_nxt_s[r] = 1'b0;
      end else if (set_s) begin
        busy_nxt_s[r] = 1'b1;
      end else if (clr_s) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
      cnt_nxt_s = cnt_nxt_s + {{ADDR_W{1'b0}}, busy_nxt_s[r]};
    end
  end

  // Busy vector and count registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      busy_r <= {NREGS{1'b0}};
      cnt_r  <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign busy_vec = busy_r;
  assign busy_cnt = cnt_r;

endmodule

// File: rtl/register_file_sb.sv
// Dual-write, N-read register file with same-cycle write-to-read forwarding
// and a busy scoreboard for pending writebacks.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic [N_RD*ADDR_W-1:0]   Read_Reg,
  output logic [N_RD*DATA_W-1:0]   Read_Data,
  output logic [N_RD-1:0]          Read_Busy,
  input  logic                     WrEnA,
  input  logic [ADDR_W-1:0]        WrRegA,
  input  logic [DATA_W-1:0]        WrDataA,
  input  logic                     WrEnB,
  input  logic [ADDR_W-1:0]        WrRegB,
  input  logic [DATA_W-1:0]        WrDataB,
  input  logic                     IssueEn,
  input  logic [ADDR_W-1:0]        IssueReg,
  output logic [ADDR_W:0]          Busy_Cnt
);

  localparam int NREGS = nregs(ADDR_W);
  localparam bit BYP   = (BYPASS != 0);
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [NREGS-1:0]  busy_s;
  logic              wr_a_ok_s;
  logic              wr_b_ok_s;
  logic              wr_a_live_s;
  logic              wr_b_live_s;

  assign wr_a_ok_s = WrEnA && !(ZR && (WrRegA == {ADDR_W{1'b0}}));
  assign wr_b_ok_s = WrEnB && !(ZR && (WrRegB == {ADDR_W{1'b0}}));
  // Forwarding is suppressed while reset is held so reads stay at zero.
  assign wr_a_live_s = wr_a_ok_s && reset;
  assign wr_b_live_s = wr_b_ok_s && reset;

  // Storage array; port B is written last so it wins an address collision.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr_a_ok_s) begin
        regs_r[WrRegA] <= WrDataA;
      end
      if (wr_b_ok_s) begin
        regs_r[WrRegB] <= WrDataB;
      end
    end
  end

  regfile_busy_tracker #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .Clk       (Clk),
    .reset     (reset),
    .issue_en  (IssueEn),
    .issue_reg (IssueReg),
    .wr_en_a   (WrEnA),
    .wr_reg_a  (WrRegA),
    .wr_en_b   (WrEnB),
    .wr_reg_b  (WrRegB),
    .busy_vec  (busy_s),
    .busy_cnt  (Busy_Cnt)
  );

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_rd_s;
    logic              hit_a_s;
    logic              hit_b_s;

    assign addr_s = Read_Reg[i*ADDR_W +: ADDR_W];

    // Per-port read mux: zero register, then B-forward, A-forward, stored value.
    always_comb begin
      hit_a_s   = BYP && wr_a_live_s && (WrRegA == addr_s);
      hit_b_s   = BYP && wr_b_live_s && (WrRegB == addr_s);
      data_s    = {DATA_W{1'b0}};
      busy_rd_s = 1'b0;
      if (ZR && (addr_s == {ADDR_W{1'b0}})) begin
        data_s    = {DATA_W{1'b0}};
        busy_rd_s = 1'b0;
      end else if (hit_b_s) begin
        data_s    = WrDataB;
        busy_rd_s = 1'b0;
      end else if (hit_a_s) begin
        data_s    = WrDataA;
        busy_rd_s = 1'b0;
      end else begin
        data_s    = regs_r[addr_s];
        busy_rd_s = busy_s[addr_s];
      end
    end

    assign Read_Data[i*DATA_W +: DATA_W] = data_s;
    assign Read_Busy[i]                  = busy_rd_s;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: a forwarding instance and a
// non-forwarding single-read instance share the write/issue stimulus.
module tb_register_file_sb;

  logic        Clk;
  logic        reset;
  logic [9:0]  rd_reg;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en_a;
  logic [4:0]  wr_reg_a;
  logic [31:0] wr_data_a;
  logic        wr_en_b;
  logic [4:0]  wr_reg_b;
  logic [31:0] wr_data_b;
  logic        issue_en;
  logic [4:0]  issue_reg;
  logic [5:0]  busy_cnt;
  logic [4:0]  nb_reg;
  logic [31:0] nb_data;
  logic [0:0]  nb_busy;
  logic [5:0]  nb_cnt;

  int checks   = 0;
  int failures = 0;

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .BYPASS(1), .ZERO_REG(1)) dut (
    .Clk(Clk), .reset(reset), .Read_Reg(rd_reg), .Read_Data(rd_data), .Read_Busy(rd_busy),
    .WrEnA(wr_en_a), .WrRegA(wr_reg_a), .WrDataA(wr_data_a),
    .WrEnB(wr_en_b), .WrRegB(wr_reg_b), .WrDataB(wr_data_b),
    .IssueEn(issue_en), .IssueReg(issue_reg), .Busy_Cnt(busy_cnt)
  );

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .N_RD(1), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .Clk(Clk), .reset(reset), .Read_Reg(nb_reg), .Read_Data(nb_data), .Read_Busy(nb_busy),
    .WrEnA(wr_en_a), .WrRegA(wr_reg_a), .WrDataA(wr_data_a),
    .WrEnB(wr_en_b), .WrRegB(wr_reg_b), .WrDataB(wr_data_b),
    .IssueEn(issue_en), .IssueReg(issue_reg), .Busy_Cnt(nb_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_writes();
    wr_en_a  = 1'b0;
    wr_en_b  = 1'b0;
    issue_en = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    rd_reg    = {5'd2, 5'd1};
    nb_reg    = 5'd1;
    wr_en_a   = 1'b1;
    wr_reg_a  = 5'd1;
    wr_data_a = 32'd5;
    wr_en_b   = 1'b0;
    wr_reg_b  = 5'd0;
    wr_data_b = 32'd0;
    issue_en  = 1'b1;
    issue_reg = 5'd6;

    // Reset held: no forwarding, no busy, count zero; edge at t=5 is discarded.
    #2;
    chk("rst_held_data", rd_data, 64'd0);
    chk("rst_held_busy", {62'd0, rd_busy}, 64'd0);
    chk("rst_held_cnt", {58'd0, busy_cnt}, 64'd0);
    @(negedge Clk);
    reset = 1'b1;
    idle_writes();
    #1;
    chk("rst_rel_data", rd_data, 64'd0);
    chk("rst_rel_busy", {62'd0, rd_busy}, 64'd0);
    chk("rst_rel_cnt", {58'd0, busy_cnt}, 64'd0);

    // Write A reg 3 = 56 with same-cycle read.
    wr_en_a = 1'b1; wr_reg_a = 5'd3; wr_data_a = 32'd56;
    rd_reg = {5'd2, 5'd3}; nb_reg = 5'd3;
    #1;
    chk("byp_same_cycle", {32'd0, rd_data[31:0]}, 64'd56);
    chk("nobyp_same_cycle", {32'd0, nb_data}, 64'd0);
    tick();
    idle_writes();
    #1;
    chk("byp_after_edge", {32'd0, rd_data[31:0]}, 64'd56);
    chk("nobyp_after_edge", {32'd0, nb_data}, 64'd56);
    chk("write_nonbusy_cnt", {58'd0, busy_cnt}, 64'd0);

    // A/B collision on reg 5: B wins.
    wr_en_a = 1'b1; wr_reg_a = 5'd5; wr_data_a = 32'h11;
    wr_en_b = 1'b1; wr_reg_b = 5'd5; wr_data_b = 32'h22;
    rd_reg = {5'd5, 5'd5}; nb_reg = 5'd5;
    #1;
    chk("coll_byp_p0", {32'd0, rd_data[31:0]}, 64'h22);
    chk("coll_byp_p1", {32'd0, rd_data[63:32]}, 64'h22);
    tick();
    idle_writes();
    #1;
    chk("coll_stored", {32'd0, rd_data[31:0]}, 64'h22);
    chk("coll_stored_nb", {32'd0, nb_data}, 64'h22);

    // Zero register: write and issue to reg 0 are ignored.
    wr_en_a = 1'b1; wr_reg_a = 5'd0; wr_data_a = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_reg = 5'd0;
    rd_reg = {5'd3, 5'd0}; nb_reg = 5'd0;
    #1;
    chk("zero_same_cycle", {32'd0, rd_data[31:0]}, 64'd0);
    tick();
    idle_writes();
    #1;
    chk("zero_data", {32'd0, rd_data[31:0]}, 64'd0);
    chk("zero_data_nb", {32'd0, nb_data}, 64'd0);
    chk("zero_busy", {63'd0, rd_busy[0]}, 64'd0);
    chk("zero_cnt", {58'd0, busy_cnt}, 64'd0);

    // Scoreboard: issue 7 then 9.
    issue_en = 1'b1; issue_reg = 5'd7; rd_reg = {5'd9, 5'd7};
    tick();
    chk("sb_cnt1", {58'd0, busy_cnt}, 64'd1);
    chk("sb_busy7", {63'd0, rd_busy[0]}, 64'd1);
    issue_reg = 5'd9;
    tick();
    chk("sb_cnt2", {58'd0, busy_cnt}, 64'd2);
    chk("sb_busy9", {63'd0, rd_busy[1]}, 64'd1);

    // Write B and issue to reg 7 together: forwarded read not busy, bit stays set.
    issue_reg = 5'd7;
    wr_en_b = 1'b1; wr_reg_b = 5'd7; wr_data_b = 32'h77;
    #1;
    chk("sb_fwd_busy", {63'd0, rd_busy[0]}, 64'd0);
    chk("sb_fwd_data", {32'd0, rd_data[31:0]}, 64'h77);
    tick();
    idle_writes();
    #1;
    chk("sb_reissue_busy", {63'd0, rd_busy[0]}, 64'd1);
    chk("sb_reissue_cnt", {58'd0, busy_cnt}, 64'd2);
    chk("sb_reissue_cnt_nb", {58'd0, nb_cnt}, 64'd2);

    // Writeback on reg 9 clears it.
    wr_en_a = 1'b1; wr_reg_a = 5'd9; wr_data_a = 32'h99;
    tick();
    idle_writes();
    #1;
    chk("sb_clr_cnt", {58'd0, busy_cnt}, 64'd1);
    chk("sb_clr_busy9", {63'd0, rd_busy[1]}, 64'd0);
    chk("sb_clr_data9", {32'd0, rd_data[63:32]}, 64'h99);

    // Issue 10, then clear 7 and 10 in one edge: count drops by two.
    issue_en = 1'b1; issue_reg = 5'd10;
    tick();
    idle_writes();
    #1;
    chk("sb_cnt_before_dec2", {58'd0, busy_cnt}, 64'd2);
    wr_en_a = 1'b1; wr_reg_a = 5'd7; wr_data_a = 32'd1;
    wr_en_b = 1'b1; wr_reg_b = 5'd10; wr_data_b = 32'd2;
    tick();
    idle_writes();
    #1;
    chk("sb_dec2_cnt", {58'd0, busy_cnt}, 64'd0);

    // Async reset mid-operation.
    issue_en = 1'b1;
    for (int k = 11; k <= 13; k++) begin
      issue_reg = 5'(k);
      tick();
    end
    issue_en = 1'b0;
    wr_en_a = 1'b1; wr_reg_a = 5'd4; wr_data_a = 32'd20;
    tick();
    idle_writes();
    rd_reg = {5'd11, 5'd4}; nb_reg = 5'd4;
    #1;
    chk("pre_rst_cnt", {58'd0, busy_cnt}, 64'd3);
    chk("pre_rst_data4", {32'd0, rd_data[31:0]}, 64'd20);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_cnt", {58'd0, busy_cnt}, 64'd0);
    chk("mid_rst_data4", {32'd0, rd_data[31:0]}, 64'd0);
    chk("mid_rst_busy11", {63'd0, rd_busy[1]}, 64'd0);
    wr_en_a = 1'b1; wr_reg_a = 5'd4; wr_data_a = 32'd33;
    issue_en = 1'b1; issue_reg = 5'd4;
    tick();
    chk("rst_write_discard", {32'd0, rd_data[31:0]}, 64'd0);
    @(negedge Clk);
    idle_writes();
    reset = 1'b1;
    #1;
    chk("post_rst_data4", {32'd0, rd_data[31:0]}, 64'd0);
    chk("post_rst_data4_nb", {32'd0, nb_data}, 64'd0);
    chk("post_rst_cnt", {58'd0, busy_cnt}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the single-write, two-read register_file.
- Adds configurable width, depth and read-port count, a second write port and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard so the pipelined datapath can detect pending writebacks.
- Sits between decode (reads, issue), EX/ALU writeback (port A) and load/MEM writeback (port B).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; NREGS = 2**ADDR_W
N_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see stored value only
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy

Ports:
Clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
Read_Reg  in  N_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
Read_Data  out  N_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
Read_Busy  out  N_RD  busy flag of addressed register, per port
WrEnA  in  1  write enable, port A
WrRegA  in  ADDR_W  write address, port A
WrDataA  in  DATA_W  write data, port A
WrEnB  in  1  write enable, port B
WrRegB  in  ADDR_W  write address, port B
WrDataB  in  DATA_W  write data, port B
IssueEn  in  1  mark destination register as pending
IssueReg  in  ADDR_W  destination register to mark busy
Busy_Cnt  out  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (reset=0, asynchronous, dominates Clk): all NREGS registers = 0, all busy bits = 0, Busy_Cnt = 0.
  - Read paths are combinational, so Read_Data = 0 and Read_Busy = 0 while reset is held.
  - Reset asserted mid-write discards that write.
- Writes:
  - On rising Clk, port A writes WrDataA to WrRegA when WrEnA=1; same for port B.
  - With ZERO_REG=1, writes to address 0 are ignored.
  - A/B same-address collision: port B wins (load writeback is the younger result by pipeline contract).
- Reads (combinational, zero latency):
  - Read_Data[i] = reg[Read_Reg[i]].
  - ZERO_REG=1 and address 0: result is 0 regardless of writes.
  - BYPASS=1 and a write enable hits the read address this cycle: return the write data, with B priority over A.
  - BYPASS=0: the new value is visible from the cycle after the edge.
- Scoreboard:
  - busy[r] is set at the edge when IssueEn=1 and IssueReg=r.
  - busy[r] is cleared at the edge when any enabled write targets r.
  - Issue and write to the same r in the same cycle: busy stays set (new producer wins).
  - Issue to an already-busy r: remains set, no count change.
  - Write to a non-busy r: busy unchanged.
  - ZERO_REG=1: busy[0] is never set.
- Read_Busy[i]:
  - Equals busy[Read_Reg[i]].
  - When BYPASS=1 and a same-cycle write hits that address: 0 (data is forwarded), even if IssueEn targets it.
- Busy_Cnt:
  - Registered population count of the busy vector; updated at the same edge as busy.
  - Net change per cycle is in {-2, -1, 0, +1}.
  - Never exceeds NREGS (NREGS-1 with ZERO_REG=1), so the width never overflows.
- Port ordering: all ports are independent; any number of read ports may address the same register.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W constants and a localparam function for NREGS.
- Sub-module regfile_busy_tracker: busy vector, set/clear priority and Busy_Cnt counter.
  - Inputs: Clk, reset, issue and both write enables/addresses.
  - Output: busy vector and count.
- Top level holds the storage array, write logic and per-port bypass muxes, generated over N_RD.

Test Plan:
1. Reset then read: reset=0 then 1, Read_Reg={1,2} -> Read_Data={0,0}, Read_Busy=0, Busy_Cnt=0.
2. Write and bypass (BYPASS=1): WrEnA, reg 3 = 56, Read_Reg0=3 in the same cycle -> Read_Data0=56 in that cycle. With BYPASS=0 the value is 0 in that cycle and 56 after the edge.
3. Collision: WrEnA reg 5 = 0x11, WrEnB reg 5 = 0x22 -> after edge reg 5 = 0x22; same-cycle bypass read = 0x22.
4. Zero register: WrEnA reg 0 = 0xFFFFFFFF plus IssueEn reg 0 -> Read_Data=0, Read_Busy=0, Busy_Cnt=0.
5. Scoreboard: issue 7, then issue 9 -> Busy_Cnt 1 then 2.
   - WrEnB reg 7 with IssueEn reg 7 in the same cycle -> busy[7] stays 1, Busy_Cnt=2.
   - Next cycle WrEnA reg 9 -> Busy_Cnt=1.
6. Async reset mid-operation: busy 3 registers, reg 4 = 20, pulse reset low between edges -> immediately Busy_Cnt=0, Read_Data(reg 4)=0; a pending write on the next edge with reset low is discarded.
